// File: rtl/pwm_timebase_counter.sv
// pwm_timebase_counter: prescaled up/down/centre-aligned PWM timebase with shadowed
// period/prescale/mode, one-shot operation and registered overflow/underflow events.
module pwm_timebase_counter #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [1:0]       mode,
    input  logic             one_shot,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic             dir,
    output logic             tick,
    output logic             ovf,
    output logic             unf,
    output logic             running
);
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_UD   = 2'b10;

    logic [CNT_W-1:0] act_period;
    logic [PSC_W-1:0] act_psc;
    logic [PSC_W-1:0] psc_cnt;
    logic [1:0]       act_mode;
    logic             en_q;
    logic [CNT_W-1:0] next_cnt;
    logic             next_dir;
    logic             next_ovf;
    logic             next_unf;
    logic             boundary;
    logic             load;

    assign tick = running && (psc_cnt == act_psc);
    assign load = !en || count_reset || (tick && boundary);

    // Next count and events assuming this cycle ticks; boundary marks where shadows may load.
    always_comb begin
        next_cnt = count_val;
        next_dir = dir;
        next_ovf = 1'b0;
        next_unf = 1'b0;
        boundary = 1'b0;
        if (act_mode == M_UD) begin
            if (act_period == '0) begin
                next_cnt = '0;
                next_dir = 1'b1;
                next_ovf = 1'b1;
                next_unf = 1'b1;
                boundary = 1'b1;
            end else if (dir) begin
                next_cnt = count_val >= act_period ? act_period - CNT_W'(1) : count_val + CNT_W'(1);
                next_dir = !(count_val >= act_period);
                next_ovf = count_val >= act_period;
            end else begin
                next_cnt = count_val == '0 ? CNT_W'(1) : count_val - CNT_W'(1);
                next_dir = count_val == '0;
                next_unf = count_val == '0;
                boundary = count_val == '0;
            end
        end else if (act_mode == M_DOWN) begin
            next_dir = 1'b0;
            next_cnt = count_val == '0 ? act_period : count_val - CNT_W'(1);
            next_unf = count_val == '0;
            boundary = count_val == '0;
        end else begin
            next_dir = 1'b1;
            next_cnt = count_val >= act_period ? '0 : count_val + CNT_W'(1);
            next_ovf = count_val >= act_period;
            boundary = count_val >= act_period;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_val  <= '0;
            dir        <= 1'b1;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            running    <= 1'b0;
            psc_cnt    <= '0;
            act_period <= '0;
            act_psc    <= '0;
            act_mode   <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q <= en;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            if (load) begin
                act_period <= period;
                act_psc    <= prescale;
                act_mode   <= mode;
            end
            if (count_reset) begin
                psc_cnt   <= '0;
                count_val <= mode == M_DOWN ? period : '0;
                dir       <= mode != M_DOWN;
            end else if (tick) begin
                psc_cnt   <= '0;
                count_val <= next_cnt;
                dir       <= next_dir;
                ovf       <= next_ovf;
                unf       <= next_unf;
            end else if (running) begin
                psc_cnt <= psc_cnt + PSC_W'(1);
            end
            if (count_reset && en)
                running <= 1'b1;
            else if (!en)
                running <= 1'b0;
            else if (tick && boundary && one_shot)
                running <= 1'b0;
            else if (!en_q)
                running <= 1'b1;
        end
    end
endmodule

// File: doc/pwm_timebase_counter.md
Name: pwm_timebase_counter

Overview:
Parametrised timebase for the PWM generator. It supersedes the fixed 16-bit up/down counter. It adds:
- configurable counter and prescaler widths;
- an up-down (centre-aligned) mode;
- shadowed period, prescale and mode, with glitch-free updates at cycle boundaries;
- one-shot operation;
- registered overflow and underflow event pulses for the compare/output stages and the interrupt logic.

Parameters:
CNT_W, 16, counter and period width in bits (2..32)
PSC_W, 8, prescaler width in bits (1..16)

Ports:
clk  input  1  clock; all logic is synchronous to its rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  counter enable (control register)
count_reset  input  1  one-cycle software restart pulse
mode  input  2  00 up, 01 down, 10 up-down, 11 treated as up
one_shot  input  1  1 = stop after first boundary event
period  input  CNT_W  shadow period N
prescale  input  PSC_W  shadow prescale P; count rate = clk/(P+1)
count_val  output  CNT_W  current counter value
dir  output  1  current direction, 1 = up
tick  output  1  combinational; high in cycles where the counter steps
ovf  output  1  registered one-cycle pulse on top event
unf  output  1  registered one-cycle pulse on bottom event
running  output  1  counter is actively counting

Behaviour:
- Reset values:
  - count_val = 0, dir = 1, ovf = unf = 0, running = 0.
  - Prescaler count = 0.
  - Active period, prescale and mode = 0.
  - Registered en_q = 0.
- Active registers (act_period, act_psc, act_mode) load from the inputs in these cases:
  - every cycle while en = 0;
  - on count_reset;
  - on the boundary tick, i.e. the up wrap, the down reload, or the up-down bottom event.
- Input changes while running take effect only at the next boundary.
- running:
  - Set in the cycle after en rises (en & !en_q) or on count_reset with en = 1.
  - Cleared when en = 0.
  - Cleared at a boundary event when one_shot = 1.
- Prescaler:
  - Counts only when running.
  - tick = running & (psc_cnt == act_psc). On tick, psc_cnt returns to 0; otherwise it increments.
  - act_psc = 0 gives a tick every clk.
- Hold: when running = 0, count_val, dir and psc_cnt hold their values.
- Up mode, on tick:
  - If count_val >= act_period: count_val <= 0, ovf pulse. The >= guard covers values left over from a mode change.
  - Otherwise count_val + 1.
  - Cycle length = (N+1)(P+1) clk. dir = 1.
- Down mode, on tick:
  - If count_val == 0: count_val <= act_period, unf pulse.
  - Otherwise count_val - 1.
  - Cycle length = (N+1)(P+1). dir = 0.
- Up-down mode, on tick:
  - Up phase: at count_val >= act_period, dir <= 0, count_val <= act_period - 1, ovf pulse.
  - Down phase: at count_val == 0, dir <= 1, count_val <= 1, unf pulse. This is the boundary event.
  - Cycle length = 2N ticks.
  - N = 0: count_val stays 0 and both ovf and unf pulse on every tick.
  - N = 1: sequence is 0, 1, 0, 1, …
- Event timing: ovf/unf are asserted in the same cycle the new count_val is visible. They are never asserted without a tick.
- count_reset:
  - Highest priority after rst_n; acts regardless of tick and regardless of en.
  - psc_cnt <= 0; active registers load.
  - count_val <= 0 with dir <= 1 in up and up-down modes.
  - count_val <= period input with dir <= 0 in down mode.
  - No ovf/unf pulse.
- One-shot: after the boundary event, running = 0 and count_val holds the post-boundary value:
  - 0 after an up wrap;
  - N after a down reload;
  - 1 after an up-down bottom event.
  - Restart by count_reset, or by toggling en low then high.
- Reset mid-operation: rst_n low forces all reset values asynchronously. After release, counting starts only on a fresh en rising edge or count_reset. en already high at release counts as a rising edge via en_q = 0.
- Arithmetic: all counter and prescaler arithmetic is modulo 2^CNT_W and 2^PSC_W; there are no other wrap paths.

Test Plan:
- Up mode, N = 4, P = 0, en rising: count_val 0,1,2,3,4,0,… changing every clk; ovf high exactly when count_val returns to 0, period 5 clk.
- Down mode, N = 3, P = 2: count_val steps every 3 clk through 3,2,1,0,3; unf coincides with each reload to 3; tick high one cycle in every 3.
- Up-down, N = 3, P = 0: sequence 0,1,2,3,2,1,0,1; ovf with 2 after 3; unf with 1 after 0; dir toggles accordingly; cycle 6 clk.
- Shadow update, up mode: change period from 9 to 4 while count_val = 6; counter continues to 9, wraps to 0, then wraps at 4; prescale change behaves the same.
- One-shot up mode, N = 2: count_val 0,1,2,0, then running = 0 and holds 0 with no further ovf; count_reset restarts it; en toggle also restarts it.
- count_reset on a tick cycle with count_val = N in up mode: count_val = 0 and no ovf; rst_n asserted mid-count clears all outputs immediately.
